glenn_sample_scheduler: RTL and testbench
=========================================

GLENN_SAMPLE_SCHEDULER -- requirements
Module: glenn_sample_scheduler

Interface
REQ-001 Parameter DATA_W, default 8, sample and transmit data width in bits.
REQ-002 Parameter DEPTH, default 8, sample buffer entries; SHALL be a power of two, at least 2.
REQ-003 Parameter ACK_TIMEOUT, default 15, maximum cycles to wait for in_SampleAck; range 1..255.
REQ-004 in_Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 in_Rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of in_Clk.
REQ-006 in_RecordTick  input  1  one-cycle pulse requesting one sample capture.
REQ-007 in_TransmitTick  input  1  one-cycle pulse requesting a flush of the buffer.
REQ-008 out_SampleReq  output  1  request to the sensor front end; held high until ack or timeout.
REQ-009 in_SampleAck  input  1  sensor ack; in_SampleData is valid in the same cycle.
REQ-010 in_SampleData  input  DATA_W  sample value.
REQ-011 out_TxValid  output  1  transmit data valid.
REQ-012 out_TxData  output  DATA_W  transmit data; oldest buffered sample first.
REQ-013 in_TxReady  input  1  downstream ready; transfer occurs when out_TxValid and in_TxReady are both high.
REQ-014 out_TxLast  output  1  high with the final word of a flush.
REQ-015 out_Count  output  log2(DEPTH)+1  number of samples currently buffered.
REQ-016 out_Overflow  output  1  sticky: a record tick was dropped because the buffer was full.
REQ-017 out_SampleErr  output  1  one-cycle pulse: ack timeout occurred.
REQ-018 out_Busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, SAMPLE and TRANSMIT.
REQ-020 A tick SHALL set its pending flag (rec_pend, tx_pend); a flag set while already set SHALL be a no-op, so at most one of each is queued.
REQ-021 IDLE SHALL pick on the cycle after a flag is set; rec_pend SHALL take priority over tx_pend; the chosen flag SHALL clear on departure.
REQ-022 When both ticks arrive in the same cycle, SAMPLE SHALL run first and TRANSMIT SHALL follow, with no IDLE cycle between them beyond the one required by REQ-021.
REQ-023 When rec_pend is chosen with out_Count==DEPTH: no SAMPLE entry, rec_pend clears, out_Overflow sets, and the FSM stays IDLE.
REQ-024 SAMPLE: out_SampleReq high from the first SAMPLE cycle until and including the ack cycle; the ack cycle writes in_SampleData and increments out_Count; the next cycle is IDLE.
REQ-025 SAMPLE timeout: a counter starts at 0 on entry; with no ack after ACK_TIMEOUT SAMPLE cycles, the next cycle drops out_SampleReq, pulses out_SampleErr for one cycle, enters IDLE, and leaves the buffer unchanged.
REQ-026 TRANSMIT entry with out_Count==0: no out_TxValid, return to IDLE the next cycle.
REQ-027 TRANSMIT otherwise: out_TxValid high from the first TRANSMIT cycle; out_TxData and out_TxLast held stable while out_TxValid && !in_TxReady.
REQ-028 Each accepted transfer SHALL pop one entry, decrement out_Count, and present the next entry on the following cycle (zero-bubble streaming).
REQ-029 Only entries present at TRANSMIT entry are flushed; out_TxLast is high exactly on the final such word; IDLE follows its acceptance.
REQ-030 out_Overflow SHALL clear on acceptance of a word with out_TxLast high; a record tick dropped in that same cycle SHALL leave it set.
REQ-031 Ticks arriving during SAMPLE or TRANSMIT SHALL only set pending flags and SHALL never abort the current operation.
REQ-032 The buffer is a circular FIFO with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0; out_Count is a separate counter.
REQ-033 out_TxValid, out_SampleReq, out_TxLast, out_SampleErr and out_Busy SHALL be registered outputs.

Reset
REQ-034 While in_Rst_n==0 at a clock edge: state IDLE, pointers and out_Count 0, pending flags 0, timeout counter 0, and all outputs 0.
REQ-035 Reset asserted mid-SAMPLE or mid-TRANSMIT SHALL abandon the operation; buffered data is lost, and out_SampleReq and out_TxValid are low from the next cycle.
REQ-036 Buffer RAM contents need not be reset; out_TxData SHALL be 0 whenever out_TxValid==0.

Verification
REQ-037 Three record ticks, ack 2 cycles after each request, data 0x11/0x22/0x33; transmit tick with in_TxReady=1 -> out_TxData 0x11,0x22,0x33 on consecutive cycles, out_TxLast on 0x33, out_Count ends at 0.
REQ-038 Record tick, ack never asserted, ACK_TIMEOUT=15 -> out_SampleReq high for exactly 15 cycles, then out_SampleErr pulses once and out_Count stays 0.
REQ-039 DEPTH=8: 9 record ticks, all acked -> out_Count=8, out_Overflow=1; a flush of 8 words -> out_Overflow=0 after the last word is accepted.
REQ-040 in_RecordTick and in_TransmitTick in the same cycle with 2 samples buffered -> SAMPLE completes first, then a flush of 3 words.
REQ-041 Flush with in_TxReady toggling 1,0,0,1 -> out_TxData held stable while stalled; no words lost or duplicated.
REQ-042 in_Rst_n driven low on the 2nd word of a 4-word flush -> next cycle out_TxValid=0, out_Count=0, out_Busy=0.

Source files
------------

// File: rtl/glenn_sample_scheduler.sv
// Sample scheduler: captures sensor samples into a circular buffer on record ticks and flushes them oldest-first on transmit ticks.
// Latency: a tick is acted on two cycles after it pulses (pending flag, then IDLE pick); a flush streams one word per cycle.
// Backpressure: out_TxValid/in_TxReady handshake holds data and last stable while stalled; sensor ack waits at most ACK_TIMEOUT cycles.
module glenn_sample_scheduler #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   in_Clk,
    input  logic                   in_Rst_n,
    input  logic                   in_RecordTick,
    input  logic                   in_TransmitTick,
    output logic                   out_SampleReq,
    input  logic                   in_SampleAck,
    input  logic [DATA_W-1:0]      in_SampleData,
    output logic                   out_TxValid,
    output logic [DATA_W-1:0]      out_TxData,
    input  logic                   in_TxReady,
    output logic                   out_TxLast,
    output logic [$clog2(DEPTH):0] out_Count,
    output logic                   out_Overflow,
    output logic                   out_SampleErr,
    output logic                   out_Busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_TRANSMIT
    } state_t;

    state_t            state;
    logic              rec_pend;
    logic              tx_pend;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [7:0]        ack_cnt;
    logic [CW-1:0]     tx_remaining;
    logic [DATA_W-1:0] mem [DEPTH];

    logic take_rec;
    logic take_tx;
    logic sample_wr;

    // IDLE decides on the flags as they stand; record work always wins over a flush.
    always_comb begin
        take_rec  = (state == ST_IDLE) && rec_pend;
        take_tx   = (state == ST_IDLE) && !rec_pend && tx_pend;
        sample_wr = (state == ST_SAMPLE) && in_SampleAck;
    end

    // Pending flags: a tick only ever sets its flag; the flag is cleared when IDLE takes it.
    always_ff @(posedge in_Clk) begin
        if (!in_Rst_n) begin
            rec_pend <= 1'b0;
            tx_pend  <= 1'b0;
        end else begin
            rec_pend <= take_rec ? 1'b0 : (rec_pend | in_RecordTick);
            tx_pend  <= take_tx  ? 1'b0 : (tx_pend  | in_TransmitTick);
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge in_Clk) begin
        if (in_Rst_n && sample_wr) begin
            mem[wr_ptr] <= in_SampleData;
        end
    end

    // The read side never races a write: writes only occur in SAMPLE, reads only in TRANSMIT.
    assign out_TxData = out_TxValid ? mem[rd_ptr] : '0;

    // Control FSM with all handshake and status outputs registered alongside the state.
    always_ff @(posedge in_Clk) begin
        if (!in_Rst_n) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            out_Count     <= '0;
            ack_cnt       <= '0;
            tx_remaining  <= '0;
            out_SampleReq <= 1'b0;
            out_TxValid   <= 1'b0;
            out_TxLast    <= 1'b0;
            out_Overflow  <= 1'b0;
            out_SampleErr <= 1'b0;
            out_Busy      <= 1'b0;
        end else begin
            out_SampleErr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_rec) begin
                        if (out_Count == CW'(DEPTH)) begin
                            // Buffer full: the capture is dropped and remembered.
                            out_Overflow <= 1'b1;
                        end else begin
                            state         <= ST_SAMPLE;
                            out_SampleReq <= 1'b1;
                            ack_cnt       <= '0;
                            out_Busy      <= 1'b1;
                        end
                    end else if (take_tx) begin
                        state    <= ST_TRANSMIT;
                        out_Busy <= 1'b1;
                        // Snapshot the occupancy: only these entries belong to this flush.
                        if (out_Count != '0) begin
                            out_TxValid  <= 1'b1;
                            tx_remaining <= out_Count;
                            out_TxLast   <= (out_Count == CW'(1));
                        end
                    end
                end

                ST_SAMPLE: begin
                    if (in_SampleAck) begin
                        wr_ptr        <= wr_ptr + 1'b1;
                        out_Count     <= out_Count + 1'b1;
                        out_SampleReq <= 1'b0;
                        out_Busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end else if (ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
                        out_SampleReq <= 1'b0;
                        out_SampleErr <= 1'b1;
                        out_Busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end

                ST_TRANSMIT: begin
                    if (!out_TxValid) begin
                        // Empty flush: nothing to send, go straight back.
                        out_Busy <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (in_TxReady) begin
                        rd_ptr       <= rd_ptr + 1'b1;
                        out_Count    <= out_Count - 1'b1;
                        tx_remaining <= tx_remaining - 1'b1;
                        if (out_TxLast) begin
                            out_TxValid  <= 1'b0;
                            out_TxLast   <= 1'b0;
                            out_Overflow <= 1'b0;
                            out_Busy     <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            out_TxLast <= (tx_remaining == CW'(2));
                        end
                    end
                end

                default: begin
                    state         <= ST_IDLE;
                    out_SampleReq <= 1'b0;
                    out_TxValid   <= 1'b0;
                    out_TxLast    <= 1'b0;
                    out_Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glenn_sample_scheduler.sv
// Bench for glenn_sample_scheduler: queue-based reference model feeds a scoreboard of expected transmit words.
// Latency: checks are made at negedge; every wait on the DUT is bounded.
// Backpressure: in_TxReady is driven randomly or from a short pattern to exercise stalls.
module tb_glenn_sample_scheduler;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rec_tick;
    logic       tx_tick;
    logic       sample_req;
    logic       sample_ack = 1'b0;
    logic [7:0] sample_data = 8'h00;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic       tx_last;
    logic [3:0] count;
    logic       overflow;
    logic       sample_err;
    logic       busy;

    always #5 clk = ~clk;

    glenn_sample_scheduler #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .in_Clk(clk), .in_Rst_n(rst_n),
        .in_RecordTick(rec_tick), .in_TransmitTick(tx_tick),
        .out_SampleReq(sample_req), .in_SampleAck(sample_ack), .in_SampleData(sample_data),
        .out_TxValid(tx_valid), .out_TxData(tx_data), .in_TxReady(tx_ready), .out_TxLast(tx_last),
        .out_Count(count), .out_Overflow(overflow), .out_SampleErr(sample_err), .out_Busy(busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } word_t;

    word_t      sb_q[$];
    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int req_hi   = 0;
    int acc_total = 0;
    int acc_times[$];
    int cyc = 0;

    int         ack_delay  = 0;
    logic [7:0] ack_data   = 8'h00;
    int         req_cycles = 0;
    int         ready_pct  = 100;
    bit         ready_pat[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Sensor model: acks after ack_delay request cycles (never, if the delay exceeds the request window).
    always @(posedge clk) begin
        #1;
        if (sample_req) begin
            if (req_cycles == ack_delay) begin
                sample_ack  = 1'b1;
                sample_data = ack_data;
            end else begin
                sample_ack  = 1'b0;
                sample_data = 8'h00;
            end
            req_cycles++;
        end else begin
            sample_ack  = 1'b0;
            sample_data = 8'h00;
            req_cycles  = 0;
        end
    end

    // Downstream sink: pattern first (while valid), otherwise random with ready_pct.
    always @(posedge clk) begin
        #1;
        if (tx_valid && ready_pat.size() > 0) tx_ready = ready_pat.pop_front();
        else tx_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // Monitor: scoreboard pops on each accepted word, plus stall stability and idle-zero data.
    word_t mon_w;
    logic  p_stall = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic  p_last = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (sample_err) err_seen++;
        if (sample_req) req_hi++;
        if (!tx_valid) begin
            chk("txdata_zero_when_idle", tx_data, 0);
        end else begin
            if (p_stall) begin
                chk("stall_data_stable", tx_data, p_data);
                chk("stall_last_stable", tx_last, p_last);
            end
            if (tx_ready) begin
                acc_total++;
                acc_times.push_back(cyc);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, required no transfer", tx_data);
                end else begin
                    mon_w = sb_q.pop_front();
                    chk("tx_data", tx_data, mon_w.d);
                    chk("tx_last", tx_last, mon_w.last);
                end
            end
        end
        p_stall = tx_valid && !tx_ready && rst_n;
        p_data  = tx_data;
        p_last  = tx_last;
    end

    // One operation: update the reference model, pulse the tick(s), wait until the DUT settles idle.
    task automatic run_op(input bit r, input bit t, input int delay, input logic [7:0] d);
        int    base_err;
        int    lows;
        int    guard;
        int    n;
        bit    exp_err;
        word_t w;
        base_err = err_seen;
        exp_err  = 1'b0;
        if (r) begin
            ack_delay = delay;
            ack_data  = d;
            if (delay < ACK_TIMEOUT) begin
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else model_ovf = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (t) begin
            n = model_q.size();
            for (int i = 0; i < n; i++) begin
                w.d    = model_q[i];
                w.last = (i == n - 1);
                sb_q.push_back(w);
            end
            if (n > 0) model_ovf = 1'b0;
            model_q.delete();
        end
        rec_tick = r;
        tx_tick  = t;
        @(posedge clk);
        #1;
        rec_tick = 1'b0;
        tx_tick  = 1'b0;
        repeat (2) @(posedge clk);
        lows  = 0;
        guard = 0;
        while (lows < 2 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (busy) lows = 0;
            else lows++;
        end
        if (guard >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: busy=%0b after %0d cycles, required idle", busy, guard);
        end
        chk("count", count, model_q.size());
        chk("overflow", overflow, model_ovf);
        chk("sample_err_pulses", err_seen - base_err, exp_err);
        chk("flush_drained", sb_q.size(), 0);
    endtask

    initial begin
        int    base_acc;
        int    base_req;
        int    guard;
        int    k;
        bit    r;
        bit    t;
        word_t w;

        rst_n    = 1'b0;
        rec_tick = 1'b0;
        tx_tick  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sample_req", sample_req, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_sample_err", sample_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_data", tx_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three captures then a full-rate flush.
        ready_pct = 100;
        run_op(1, 0, 2, 8'h11);
        run_op(1, 0, 2, 8'h22);
        run_op(1, 0, 2, 8'h33);
        base_acc = acc_times.size();
        run_op(0, 1, 0, 8'h00);
        chk("stream_words", acc_times.size() - base_acc, 3);
        if (acc_times.size() == base_acc + 3)
            chk("stream_consecutive", acc_times[base_acc + 2] - acc_times[base_acc], 2);

        // Ack never arrives: request window is exactly ACK_TIMEOUT cycles.
        base_req = req_hi;
        run_op(1, 0, 200, 8'h5A);
        chk("req_high_cycles", req_hi - base_req, ACK_TIMEOUT);

        // Overfill by one, then flush clears overflow.
        for (int i = 0; i < DEPTH + 1; i++) run_op(1, 0, $urandom_range(0, 5), 8'($urandom));
        run_op(0, 1, 0, 8'h00);

        // Both ticks together with two samples already buffered.
        run_op(1, 0, 1, 8'hA1);
        run_op(1, 0, 3, 8'hA2);
        run_op(1, 1, 2, 8'hA3);

        // Stall pattern 1,0,0,1 during a flush.
        run_op(1, 0, 0, 8'hB1);
        run_op(1, 0, 4, 8'hB2);
        run_op(1, 0, 1, 8'hB3);
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_op(0, 1, 0, 8'h00);

        // Reset while the second of four words is on the bus.
        for (int i = 0; i < 4; i++) run_op(1, 0, 1, 8'(8'hC0 + i));
        for (int i = 0; i < 4; i++) begin
            w.d    = model_q[i];
            w.last = (i == 3);
            sb_q.push_back(w);
        end
        model_q.delete();
        base_acc = acc_total;
        tx_tick  = 1'b1;
        @(posedge clk);
        #1;
        tx_tick = 1'b0;
        guard   = 0;
        while (acc_total < base_acc + 1 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL rst_flush_start: accepted %0d words, required 1", acc_total - base_acc);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midflush_rst_valid", tx_valid, 0);
        chk("midflush_rst_count", count, 0);
        chk("midflush_rst_busy", busy, 0);
        chk("midflush_rst_words", acc_total - base_acc, 2);
        sb_q.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized mix of captures, timeouts, flushes and simultaneous ticks.
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 99);
            r = (k < 70) || (k >= 92);
            t = (k >= 70);
            case ($urandom_range(0, 2))
                0:       ready_pct = 100;
                1:       ready_pct = 70;
                default: ready_pct = 40;
            endcase
            run_op(r, t, ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 14), 8'($urandom));
        end
        ready_pct = 100;
        run_op(0, 1, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
